// File: rtl/tt_reset_sequencer.sv
// Reset sequencer: waits for divider lock and the user button, counts slow_clk edges before
// releasing the design reset, and traps a stalled slow_clk in a sticky fault state.
module tt_reset_sequencer #(
   parameter int unsigned HOLD_EDGES  = 8,
   parameter int unsigned STALL_LIMIT = 64
) (
   input  logic        clk_bufg,
   input  logic        reset_n,
   input  logic        slow_clk,
   input  logic        locked,
   input  logic        ext_rst_n,
   output logic        design_rst_n,
   output logic        slow_rise,
   output logic        slow_fall,
   output logic [1:0]  state,
   output logic        stall_fault,
   output logic [15:0] slow_cycles
);

   localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);
   localparam logic [StallW-1:0] StallMax = StallW'(STALL_LIMIT);
   localparam logic [7:0] HoldLast = 8'(HOLD_EDGES - 1);

   typedef enum logic [1:0] {
      StWaitLock = 2'b00,
      StHold     = 2'b01,
      StRun      = 2'b10,
      StFault    = 2'b11
   } state_e;

   state_e            state_q, state_d;
   logic              ext_s1, ext_rst_s;
   logic              slow_q;
   logic [StallW-1:0] stall_cnt;
   logic [7:0]        edge_cnt;
   logic [15:0]       cycles_q;
   logic              enter_hold, enter_fault, leave_fault, stalled;

   // Button reset is asynchronous to clk_bufg; slow_clk and locked are sampled directly.
   always_ff @(posedge clk_bufg or negedge reset_n) begin
      if (!reset_n) begin
         ext_s1    <= 1'b0;
         ext_rst_s <= 1'b0;
         slow_q    <= 1'b0;
         slow_rise <= 1'b0;
         slow_fall <= 1'b0;
      end else begin
         ext_s1    <= ext_rst_n;
         ext_rst_s <= ext_s1;
         slow_q    <= slow_clk;
         slow_rise <= slow_clk & ~slow_q;
         slow_fall <= ~slow_clk & slow_q;
      end
   end

   always_ff @(posedge clk_bufg or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
      end else if (slow_rise || slow_fall) begin
         stall_cnt <= '0;
      end else if (stall_cnt != StallMax) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign stalled = (stall_cnt == StallMax);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StWaitLock: begin
            if (locked && ext_rst_s) state_d = StHold;
         end
         StHold, StRun: begin
            // Losing lock or the button wins over a coincident stall or hold completion.
            if (!locked || !ext_rst_s) begin
               state_d = StWaitLock;
            end else if (stalled) begin
               state_d = StFault;
            end else if (state_q == StHold && slow_rise && edge_cnt == HoldLast) begin
               state_d = StRun;
            end
         end
         StFault: begin
            if (!ext_rst_s) state_d = StWaitLock;
         end
      endcase
   end

   assign enter_hold  = (state_q == StWaitLock) && (state_d == StHold);
   assign enter_fault = (state_q != StFault) && (state_d == StFault);
   assign leave_fault = (state_q == StFault) && (state_d == StWaitLock);

   always_ff @(posedge clk_bufg or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StWaitLock;
         design_rst_n <= 1'b0;
         stall_fault  <= 1'b0;
         edge_cnt     <= '0;
         cycles_q     <= '0;
      end else begin
         state_q      <= state_d;
         design_rst_n <= (state_d == StRun);
         if (enter_fault) begin
            stall_fault <= 1'b1;
         end else if (leave_fault) begin
            stall_fault <= 1'b0;
         end
         if (enter_hold) begin
            edge_cnt <= '0;
         end else if (state_q == StHold && slow_rise) begin
            edge_cnt <= edge_cnt + 1'b1;
         end
         if (enter_hold) begin
            cycles_q <= '0;
         end else if (state_q == StRun && slow_rise) begin
            cycles_q <= cycles_q + 1'b1;
         end
      end
   end

   assign state       = state_q;
   assign slow_cycles = cycles_q;

endmodule

// File: doc/tt_reset_sequencer.md
TT_RESET_SEQUENCER -- requirements
Module: tt_reset_sequencer

Interface
REQ-001: Parameter HOLD_EDGES, default 8, number of slow_clk rising edges counted in HOLD before design reset releases; legal range 1..255.
REQ-002: Parameter STALL_LIMIT, default 64, number of clk_bufg cycles without any slow_clk edge that constitutes a stall; legal range 2..1023.
REQ-003: clk_bufg  input  1  27 MHz system clock; all logic on its rising edge.
REQ-004: reset_n  input  1  asynchronous, active-low reset of all state.
REQ-005: slow_clk  input  1  500 kHz divided clock from the clock divider, registered in the clk_bufg domain.
REQ-006: locked  input  1  divider lock status, registered in the clk_bufg domain.
REQ-007: ext_rst_n  input  1  user reset button, asynchronous to clk_bufg, active-low.
REQ-008: design_rst_n  output  1  registered active-low reset for the user design.
REQ-009: slow_rise  output  1  one-clk_bufg-cycle pulse per slow_clk rising edge.
REQ-010: slow_fall  output  1  one-clk_bufg-cycle pulse per slow_clk falling edge.
REQ-011: state  output  2  current FSM state encoding.
REQ-012: stall_fault  output  1  sticky stall indicator.
REQ-013: slow_cycles  output  16  count of slow_clk rising edges seen in RUN.

Function
REQ-014: ext_rst_n SHALL pass through a 2-flop synchronizer (ext_rst_s) before use; slow_clk and locked SHALL be used without a synchronizer.
REQ-015: slow_q SHALL register slow_clk each cycle; slow_rise/slow_fall SHALL be registered from (slow_clk & ~slow_q) and (~slow_clk & slow_q), each high exactly one cycle, 1 cycle after slow_q samples the old level.
REQ-016: The stall counter SHALL clear on any cycle where slow_rise or slow_fall is high, otherwise increment, saturating at STALL_LIMIT; it SHALL run in every state.
REQ-017: FSM states: WAIT_LOCK=00, HOLD=01, RUN=10, FAULT=11.
REQ-018: WAIT_LOCK -> HOLD when locked=1 and ext_rst_s=1; the edge counter SHALL clear on entry.
REQ-019: HOLD: the edge counter SHALL increment on each slow_rise; HOLD -> RUN on the slow_rise that brings the count to HOLD_EDGES.
REQ-020: HOLD or RUN -> WAIT_LOCK when locked=0 or ext_rst_s=0; this SHALL take priority over every other transition in the same cycle.
REQ-021: HOLD or RUN -> FAULT when the stall counter equals STALL_LIMIT and REQ-020 does not apply.
REQ-022: FAULT -> WAIT_LOCK only when ext_rst_s=0; locked changes SHALL be ignored in FAULT.
REQ-023: design_rst_n SHALL be a dedicated flop loaded with (next_state==RUN), so design_rst_n=1 exactly when state=RUN, with no combinational path to the output.
REQ-024: stall_fault SHALL set on entry to FAULT and clear only on the FAULT -> WAIT_LOCK transition or reset_n.
REQ-025: slow_cycles SHALL increment on each slow_rise while state=RUN, wrapping 0xFFFF -> 0x0000, and clear on entry to HOLD.

Reset
REQ-026: While reset_n=0: state=WAIT_LOCK, design_rst_n=0, slow_rise=0, slow_fall=0, stall_fault=0, slow_cycles=0, all counters and synchronizer flops 0.
REQ-027: Assertion of reset_n mid-operation SHALL force the REQ-026 values immediately, asynchronously; the block SHALL leave reset by reentering the REQ-018 sequence.

Verification
REQ-028: reset_n released, ext_rst_n=1, locked=1 after 10 cycles, slow_clk toggling every 27 cycles -> HOLD within 4 cycles of locked; design_rst_n=1 one cycle after the 8th slow_rise; slow_rise spacing 54 cycles.
REQ-029: In RUN, slow_clk held at 1 for 64+ cycles -> state=11, stall_fault=1, design_rst_n=0; restarting slow_clk SHALL not exit FAULT; ext_rst_n pulsed low 5 cycles -> WAIT_LOCK, stall_fault=0.
REQ-030: In RUN, locked=0 and a stall reaching STALL_LIMIT in the same cycle -> state=00, stall_fault=0.
REQ-031: In HOLD after 5 edges, ext_rst_n low -> WAIT_LOCK within 3 cycles; on release the edge count restarts from 0 and 8 more edges are required.
REQ-032: In RUN, slow_cycles preloaded near wrap by running 65536 slow_rise edges -> value reads 0x0000 after the 65536th edge; slow_fall pulses 27 cycles after each slow_rise.
REQ-033: reset_n asserted asynchronously in RUN between clock edges -> design_rst_n=0 and state=00 before the next clk_bufg edge.
